// File: rtl/ef_pwm32_seq_ctrl.sv
// Run sequencer and double-buffered cmpA/cmpB/top loader for one EF_PWM32 core.
// Shadow values reach the core only at a period boundary (or straight away when idle).
module ef_pwm32_seq_ctrl #(
    parameter int unsigned   CW      = 32,
    parameter int unsigned   NW      = 16,
    parameter logic [CW-1:0] TOP_RST = CW'(255)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_cmpa,
    input  logic          wr_cmpb,
    input  logic          wr_top,
    input  logic [CW-1:0] wdata,
    input  logic          commit,
    input  logic [NW-1:0] num_prd,
    input  logic          start,
    input  logic          stop,
    input  logic          abort,
    input  logic          prd_end,
    output logic [CW-1:0] cmpA_o,
    output logic [CW-1:0] cmpB_o,
    output logic [CW-1:0] top_o,
    output logic          en_o,
    output logic          busy,
    output logic          upd_pend,
    output logic          upd_ack,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   sh_cmpa_q, sh_cmpb_q, sh_top_q;
    logic            done_d;
    logic            apply;
    logic            pend_d;
    logic            is_idle;

    assign is_idle = (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                        cnt_d   = num_prd;
                    end
                end
                StRun: begin
                    // cnt_q == 0 is continuous mode: never decrements, never completes
                    if (prd_end && cnt_q != '0) begin
                        cnt_d = cnt_q - NW'(1);
                        if (cnt_q == NW'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                    if (stop && state_d != StIdle) begin
                        state_d = StStop;
                    end
                end
                StStop: begin
                    if (prd_end) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A commit arriving together with an accepted start loads at once, so the core
    // never starts a run on stale live values.
    always_comb begin
        apply = (upd_pend && (is_idle || prd_end)) ||
                (is_idle && commit && start && !abort);
        if (apply) begin
            pend_d = 1'b0;
        end else if (commit) begin
            pend_d = 1'b1;
        end else begin
            pend_d = upd_pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sh_cmpa_q <= '0;
            sh_cmpb_q <= '0;
            sh_top_q  <= TOP_RST;
            cmpA_o    <= '0;
            cmpB_o    <= '0;
            top_o     <= TOP_RST;
            en_o      <= 1'b0;
            busy      <= 1'b0;
            upd_pend  <= 1'b0;
            upd_ack   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_o     <= (state_d != StIdle);
            busy     <= (state_d != StIdle);
            done     <= done_d;
            upd_pend <= pend_d;
            upd_ack  <= apply;
            if (wr_cmpa) sh_cmpa_q <= wdata;
            if (wr_cmpb) sh_cmpb_q <= wdata;
            if (wr_top)  sh_top_q  <= wdata;
            // Live side takes the shadows as they stood before this cycle's writes
            if (apply) begin
                cmpA_o <= sh_cmpa_q;
                cmpB_o <= sh_cmpb_q;
                top_o  <= sh_top_q;
            end
        end
    end

endmodule

// File: tb/tb_ef_pwm32_seq_ctrl.sv
// Directed bench for ef_pwm32_seq_ctrl: run control, commit timing, abort and reset.
module tb_ef_pwm32_seq_ctrl;

    localparam int unsigned CW = 32;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_cmpa = 1'b0, wr_cmpb = 1'b0, wr_top = 1'b0;
    logic [CW-1:0] wdata = '0;
    logic          commit = 1'b0;
    logic [NW-1:0] num_prd = '0;
    logic          start = 1'b0, stop = 1'b0, abort = 1'b0, prd_end = 1'b0;
    logic [CW-1:0] cmpA_o, cmpB_o, top_o;
    logic          en_o, busy, upd_pend, upd_ack, done;

    int total = 0;
    int bad   = 0;

    ef_pwm32_seq_ctrl #(.CW(CW), .NW(NW), .TOP_RST(32'd255)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_cmpa  (wr_cmpa),
        .wr_cmpb  (wr_cmpb),
        .wr_top   (wr_top),
        .wdata    (wdata),
        .commit   (commit),
        .num_prd  (num_prd),
        .start    (start),
        .stop     (stop),
        .abort    (abort),
        .prd_end  (prd_end),
        .cmpA_o   (cmpA_o),
        .cmpB_o   (cmpB_o),
        .top_o    (top_o),
        .en_o     (en_o),
        .busy     (busy),
        .upd_pend (upd_pend),
        .upd_ack  (upd_ack),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are read 1 time unit after it, pulses then drop.
    task automatic cycle();
        @(posedge clk);
        #1;
        wr_cmpa = 1'b0; wr_cmpb = 1'b0; wr_top = 1'b0;
        commit = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; prd_end = 1'b0;
    endtask

    initial begin
        #12;
        check_eq("rst_en", en_o, 0);
        check_eq("rst_top", top_o, 255);
        check_eq("rst_cmpa", cmpA_o, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pend", upd_pend, 0);
        check_eq("rst_done", done, 0);
        rst_n = 1'b1;
        cycle();

        // Three-period run
        num_prd = 16'd3; start = 1'b1; cycle();
        check_eq("r3_en_start", en_o, 1);
        check_eq("r3_busy", busy, 1);
        cycle(); cycle();
        prd_end = 1'b1; cycle();
        check_eq("r3_en_p1", en_o, 1);
        prd_end = 1'b1; cycle();
        check_eq("r3_en_p2", en_o, 1);
        check_eq("r3_done_p2", done, 0);
        prd_end = 1'b1; cycle();
        check_eq("r3_en_p3", en_o, 0);
        check_eq("r3_done_p3", done, 1);
        check_eq("r3_busy_end", busy, 0);
        cycle();
        check_eq("r3_done_once", done, 0);
        prd_end = 1'b1; stop = 1'b1; cycle();
        check_eq("idle_ignore_en", en_o, 0);
        check_eq("idle_ignore_done", done, 0);

        // Single-period run
        num_prd = 16'd1; start = 1'b1; cycle();
        prd_end = 1'b1; cycle();
        check_eq("r1_en", en_o, 0);
        check_eq("r1_done", done, 1);

        // Continuous run, commit applied at a later prd_end
        num_prd = 16'd0; start = 1'b1; cycle();
        wdata = 32'd100; wr_cmpa = 1'b1; commit = 1'b1; cycle();
        check_eq("c_pend", upd_pend, 1);
        check_eq("c_cmpa_hold", cmpA_o, 0);
        cycle(); cycle(); cycle(); cycle();
        check_eq("c_pend_wait", upd_pend, 1);
        prd_end = 1'b1; cycle();
        check_eq("c_cmpa_load", cmpA_o, 100);
        check_eq("c_ack", upd_ack, 1);
        check_eq("c_pend_clr", upd_pend, 0);
        cycle();
        check_eq("c_ack_once", upd_ack, 0);
        check_eq("c_en_cont", en_o, 1);

        // Commit coinciding with prd_end defers; write on the load cycle hits shadow only
        wdata = 32'd200; wr_cmpa = 1'b1; commit = 1'b1; prd_end = 1'b1; cycle();
        check_eq("d_no_load", cmpA_o, 100);
        check_eq("d_no_ack", upd_ack, 0);
        check_eq("d_pend", upd_pend, 1);
        cycle();
        wdata = 32'd7; wr_cmpa = 1'b1; prd_end = 1'b1; cycle();
        check_eq("d_load_old", cmpA_o, 200);
        check_eq("d_ack", upd_ack, 1);
        commit = 1'b1; cycle();
        prd_end = 1'b1; cycle();
        check_eq("d_shadow7", cmpA_o, 7);

        // Graceful stop
        stop = 1'b1; cycle();
        check_eq("s_en_hold", en_o, 1);
        check_eq("s_busy", busy, 1);
        cycle();
        prd_end = 1'b1; cycle();
        check_eq("s_en_off", en_o, 0);
        check_eq("s_done", done, 1);

        // Stop together with prd_end finishes at the following prd_end
        num_prd = 16'd0; start = 1'b1; cycle();
        stop = 1'b1; prd_end = 1'b1; cycle();
        check_eq("sp_en", en_o, 1);
        check_eq("sp_done0", done, 0);
        prd_end = 1'b1; cycle();
        check_eq("sp_en_off", en_o, 0);
        check_eq("sp_done", done, 1);

        // Abort with an update pending
        start = 1'b1; cycle();
        wdata = 32'd55; wr_top = 1'b1; commit = 1'b1; cycle();
        check_eq("a_pend", upd_pend, 1);
        abort = 1'b1; cycle();
        check_eq("a_en", en_o, 0);
        check_eq("a_done", done, 0);
        check_eq("a_top_hold", top_o, 255);
        check_eq("a_pend_kept", upd_pend, 1);
        cycle();
        check_eq("a_top_load", top_o, 55);
        check_eq("a_ack", upd_ack, 1);
        check_eq("a_pend_clr", upd_pend, 0);

        // start + abort in IDLE stays idle
        start = 1'b1; abort = 1'b1; cycle();
        check_eq("sa_en", en_o, 0);
        check_eq("sa_busy", busy, 0);

        // Commit with start in IDLE loads no later than en_o rises
        wdata = 32'd9; wr_cmpb = 1'b1; cycle();
        commit = 1'b1; start = 1'b1; cycle();
        check_eq("cs_en", en_o, 1);
        check_eq("cs_cmpb", cmpB_o, 9);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_en", en_o, 0);
        check_eq("ar_top", top_o, 255);
        check_eq("ar_cmpb", cmpB_o, 0);
        check_eq("ar_done", done, 0);
        #3 rst_n = 1'b1;
        cycle();
        check_eq("ar_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
